// File: rtl/aes_ctrl_pkg.sv
// Shared types and sizing for the AES control path.
// Holds the loader state enum, the default block geometry and a counter-width
// helper. The PAD state only exists when FIFO_LOADER_PAD_EN is defined.
package aes_ctrl_pkg;

  localparam int unsigned BLK_BYTES_DEF = 16;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned BLK_W_DEF     = BLK_BYTES_DEF * DATA_W_DEF;

`ifdef FIFO_LOADER_PAD_EN
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_PAD  = 2'd2
  } loader_state_e;
`else
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1
  } loader_state_e;
`endif

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic wrapping counter: counts 0..rollover_val, then wraps to 0.
// Ports:
//   clk, n_rst     clock, async active-low reset
//   clear          synchronous clear to 0 (highest priority)
//   count_enable   advance by one on the rising edge
//   rollover_val   last value before wrapping
//   count_out      current count (registered)
//   rollover_flag  high while count_out == rollover_val (registered)
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_d, count_q;
  logic                    flag_d, flag_q;

  // Next count and look-ahead rollover flag.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) count_d = '0;
      else                         count_d = count_q + NUM_CNT_BITS'(1);
    end
    flag_d = (count_d == rollover_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/fifo_block_loader.sv
// Assembles FIFO bytes into BLK_BYTES-wide blocks for the AES core.
// The first byte popped lands in the most-significant byte of blk_data.
// Optional feature: define FIFO_LOADER_PAD_EN to enable end-of-packet flush,
// which zero-pads a partial block and marks it with blk_last.
// Ports:
//   clk, n_rst       clock, async active-low reset
//   fifo_empty       FIFO has no entries
//   fifo_r_data      FIFO head entry
//   fifo_r_enable    pop the FIFO head at the next edge (combinational)
//   flush            end-of-packet pulse (ignored without FIFO_LOADER_PAD_EN)
//   blk_ready        AES core accepts the presented block
//   blk_valid        blk_data holds a complete block
//   blk_data         assembled block
//   blk_last         presented block is the final padded block of a packet
module fifo_block_loader
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned BLK_BYTES = BLK_BYTES_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        fifo_empty,
  input  logic [DATA_W-1:0]           fifo_r_data,
  output logic                        fifo_r_enable,
  input  logic                        flush,
  input  logic                        blk_ready,
  output logic                        blk_valid,
  output logic [BLK_BYTES*DATA_W-1:0] blk_data,
  output logic                        blk_last
);

  localparam int unsigned BLK_W = BLK_BYTES * DATA_W;
  localparam int unsigned CNT_W = cnt_width(BLK_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_BYTES - 1);

  loader_state_e    state_d, state_q;
  logic [BLK_W-1:0] blk_data_d, blk_data_q;
  logic             blk_valid_d, blk_valid_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             pop_c;
  logic             count_en_c;

`ifdef FIFO_LOADER_PAD_EN
  logic blk_last_d, blk_last_q;
  logic flush_pend_d, flush_pend_q;
  // A flush seen during PAD belongs to the next packet; it must survive the
  // flush_pend clear at the end of the current padded block.
  logic rearm_d, rearm_q;
`endif

  // Pop only in FILL; gated by n_rst so no pop is requested during reset.
  assign pop_c         = n_rst && (state_q == ST_FILL) && !fifo_empty;
  assign fifo_r_enable = pop_c;

`ifdef FIFO_LOADER_PAD_EN
  assign count_en_c = pop_c || (state_q == ST_PAD);
`else
  assign count_en_c = pop_c;
`endif

  // Byte position within the block being assembled.
  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_byte_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (1'b0),
    .count_enable  (count_en_c),
    .rollover_val  (CNT_LAST),
    .count_out     (cnt),
    .rollover_flag (cnt_last)
  );

  // Next-state and block register update.
  always_comb begin
    state_d     = state_q;
    blk_data_d  = blk_data_q;
    blk_valid_d = blk_valid_q;
`ifdef FIFO_LOADER_PAD_EN
    blk_last_d   = blk_last_q;
    flush_pend_d = flush_pend_q;
    rearm_d      = rearm_q;
`endif

    unique case (state_q)
      ST_FILL: begin
        if (pop_c) begin
          blk_data_d = {blk_data_q[BLK_W-DATA_W-1:0], fifo_r_data};
          if (cnt_last) begin
            state_d     = ST_HOLD;
            blk_valid_d = 1'b1;
`ifdef FIFO_LOADER_PAD_EN
            blk_last_d  = 1'b0;
`endif
          end
        end
`ifdef FIFO_LOADER_PAD_EN
        else if (flush_pend_q && fifo_empty) begin
          // A pending flush with nothing collected has nothing to pad.
          if (cnt != '0) state_d      = ST_PAD;
          else           flush_pend_d = 1'b0;
        end
        if (flush && ((cnt != '0) || !fifo_empty)) flush_pend_d = 1'b1;
`endif
      end

      ST_HOLD: begin
        if (blk_ready) begin
          state_d     = ST_FILL;
          blk_valid_d = 1'b0;
`ifdef FIFO_LOADER_PAD_EN
          blk_last_d  = 1'b0;
`endif
        end
`ifdef FIFO_LOADER_PAD_EN
        if (flush) flush_pend_d = 1'b1;
`endif
      end

`ifdef FIFO_LOADER_PAD_EN
      ST_PAD: begin
        blk_data_d = {blk_data_q[BLK_W-DATA_W-1:0], {DATA_W{1'b0}}};
        if (cnt_last) begin
          state_d      = ST_HOLD;
          blk_valid_d  = 1'b1;
          blk_last_d   = 1'b1;
          flush_pend_d = rearm_q || flush;
          rearm_d      = 1'b0;
        end else if (flush) begin
          rearm_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_FILL;
      blk_data_q   <= '0;
      blk_valid_q  <= 1'b0;
`ifdef FIFO_LOADER_PAD_EN
      blk_last_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      rearm_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      blk_data_q   <= blk_data_d;
      blk_valid_q  <= blk_valid_d;
`ifdef FIFO_LOADER_PAD_EN
      blk_last_q   <= blk_last_d;
      flush_pend_q <= flush_pend_d;
      rearm_q      <= rearm_d;
`endif
    end
  end

  assign blk_data  = blk_data_q;
  assign blk_valid = blk_valid_q;

`ifdef FIFO_LOADER_PAD_EN
  assign blk_last = blk_last_q;
`else
  // Without padding, flush and the counter value have no consumer.
  logic unused_in;
  assign unused_in = flush ^ (^cnt);
  assign blk_last  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_block_loader.sv
// Scoreboard bench for fifo_block_loader: a FIFO model feeds bytes, the
// stimulus pushes expected blocks into a queue and a monitor compares every
// presented block against it.
module tb_fifo_block_loader;

  localparam int unsigned BB = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = BB * DW;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk;
  logic          n_rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_r_enable;
  logic          flush;
  logic          blk_ready;
  logic          blk_valid;
  logic [BW-1:0] blk_data;
  logic          blk_last;

  exp_t          exp_q[$];
  logic [7:0]    fq[$];
  int            total = 0;
  int            bad = 0;
  int            pop_count = 0;
  bit            stall_en = 0;
  logic [BW-1:0] acc = '0;
  int            acc_n = 0;

  fifo_block_loader #(
    .BLK_BYTES (BB),
    .DATA_W    (DW)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .fifo_empty    (fifo_empty),
    .fifo_r_data   (fifo_r_data),
    .fifo_r_enable (fifo_r_enable),
    .flush         (flush),
    .blk_ready     (blk_ready),
    .blk_valid     (blk_valid),
    .blk_data      (blk_data),
    .blk_last      (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bw(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // FIFO model: pop decided from the DUT request mid-cycle, applied on the edge.
  initial begin : fifo_model
    bit pend;
    bit stall;
    fifo_empty  = 1'b1;
    fifo_r_data = '0;
    forever begin
      @(negedge clk);
      pend = fifo_r_enable;
      @(posedge clk);
      if (pend && fq.size() > 0) begin
        fq.delete(0);
        pop_count++;
      end
      #1;
      stall       = stall_en && ($urandom_range(0, 2) == 0);
      fifo_empty  = (fq.size() == 0) || stall;
      fifo_r_data = (fq.size() > 0) ? fq[0] : 8'h00;
    end
  end

  // Monitor: compare each new block, then require stability while held.
  initial begin : monitor
    bit            held;
    logic [BW-1:0] hd;
    logic          hl;
    exp_t          e;
    held = 0;
    hd   = '0;
    hl   = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        held = 0;
      end else begin
        check1("pop_while_empty", fifo_r_enable && fifo_empty, 1'b0);
        if (blk_valid) begin
          if (!held) begin
            held = 1;
            hd   = blk_data;
            hl   = blk_last;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_block: got %h want none", blk_data);
            end else begin
              e = exp_q.pop_front();
              check_bw("blk_data", blk_data, e.data);
              check1("blk_last", blk_last, e.last);
            end
          end else begin
            check_bw("hold_data", blk_data, hd);
            check1("hold_last", blk_last, hl);
          end
          if (blk_ready) held = 0;
        end else begin
          held = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_raw(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic push_acc(input logic [7:0] b);
    fq.push_back(b);
    acc = {acc[BW-9:0], b};
    acc_n++;
    if (acc_n == BB) begin
      exp_q.push_back('{data: acc, last: 1'b0});
      acc_n = 0;
    end
  endtask

  task automatic pad_expect();
    while (acc_n != 0) begin
      acc = {acc[BW-9:0], 8'h00};
      acc_n++;
      if (acc_n == BB) begin
        exp_q.push_back('{data: acc, last: 1'b1});
        acc_n = 0;
      end
    end
  endtask

  task automatic wait_pops(input int target, input string name);
    int n = 0;
    while (pop_count < target && n < 300) begin
      cyc(1);
      n++;
    end
    check_int(name, pop_count, target);
  endtask

  task automatic wait_drain(input string name, input bit rnd_ready);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || blk_valid) && n < 3000) begin
      if (rnd_ready) blk_ready = 1'($urandom_range(0, 1));
      cyc(1);
      n++;
    end
    check_int(name, exp_q.size() + fq.size(), 0);
  endtask

  initial begin : stimulus
    int base;
    n_rst     = 1'b0;
    flush     = 1'b0;
    blk_ready = 1'b0;
    push_raw(8'h55);
    push_raw(8'h66);
    cyc(3);

    // Reset state, with FIFO non-empty so a pop request would be visible.
    @(negedge clk);
    check1("rst_valid", blk_valid, 1'b0);
    check1("rst_last", blk_last, 1'b0);
    check_bw("rst_data", blk_data, '0);
    check1("rst_ren", fifo_r_enable, 1'b0);
    fq.delete();
    cyc(2);
    n_rst = 1'b1;
    cyc(2);

    // 0x00..0x0F with ready held high.
    blk_ready = 1'b1;
    base = pop_count;
    for (int i = 0; i < 16; i++) push_raw(8'(i));
    exp_q.push_back('{data: 128'h000102030405060708090a0b0c0d0e0f, last: 1'b0});
    wait_pops(base + 16, "t1_pops");
    @(negedge clk);
    check1("t1_valid_latency", blk_valid, 1'b1);
    wait_drain("t1_drain", 0);

    // 40 bytes with ready low: exactly one block, then stall.
    blk_ready = 1'b0;
    base = pop_count;
    for (int i = 0; i < 40; i++) push_acc(8'(8'h40 + i));
    wait_pops(base + 16, "t2_pops");
    cyc(5);
    check_int("t2_stall_pops", pop_count, base + 16);
    @(negedge clk);
    check1("t2_ren_hold", fifo_r_enable, 1'b0);
    check1("t2_valid_hold", blk_valid, 1'b1);
    cyc(1);
    blk_ready = 1'b1;
    @(negedge clk);
    check1("t2_bubble_ren", fifo_r_enable, 1'b0);
    cyc(1);
    @(negedge clk);
    check1("t2_resume_ren", fifo_r_enable, 1'b1);
    check1("t2_resume_valid", blk_valid, 1'b0);
    for (int i = 0; i < 8; i++) push_acc(8'(8'h68 + i));
    wait_drain("t2_drain", 0);

    // FIFO availability and ready both toggling.
    stall_en = 1;
    for (int i = 0; i < 48; i++) push_acc(8'(i * 7 + 3));
    wait_drain("t3_drain", 1);
    stall_en  = 0;
    blk_ready = 1'b1;
    cyc(2);

`ifdef FIFO_LOADER_PAD_EN
    // Short packet: three bytes then flush.
    base = pop_count;
    push_raw(8'hA1);
    push_raw(8'hA2);
    push_raw(8'hA3);
    exp_q.push_back('{data: 128'ha1a2a300_00000000_00000000_00000000, last: 1'b1});
    wait_pops(base + 3, "t4_pops");
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    wait_drain("t4_drain", 0);

    // 20 bytes, flush while FIFO still holds data.
    base = pop_count;
    for (int i = 0; i < 20; i++) push_acc(8'(8'hB0 + i));
    wait_pops(base + 2, "t5_pops");
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    pad_expect();
    wait_drain("t5_drain", 0);
`else
    // Flush must be ignored: a partial block waits for more data.
    for (int i = 0; i < 3; i++) push_acc(8'(8'hD0 + i));
    cyc(4);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(30);
    @(negedge clk);
    check1("nopad_partial_waits", blk_valid, 1'b0);
    check1("nopad_last_tied", blk_last, 1'b0);
    for (int i = 3; i < 16; i++) push_acc(8'(8'hD0 + i));
    wait_drain("nopad_drain", 0);
`endif

    // Reset after 7 pops discards the partial block.
    base = pop_count;
    for (int i = 0; i < 10; i++) push_raw(8'(8'hE0 + i));
    wait_pops(base + 7, "t6_pops");
    n_rst = 1'b0;
    @(negedge clk);
    check1("t6_rst_valid", blk_valid, 1'b0);
    check1("t6_rst_last", blk_last, 1'b0);
    check_bw("t6_rst_data", blk_data, '0);
    check1("t6_rst_ren", fifo_r_enable, 1'b0);
    fq.delete();
    acc_n = 0;
    cyc(2);
    n_rst = 1'b1;
    cyc(1);
    for (int i = 0; i < 16; i++) push_acc(8'(8'hF0 + i));
    wait_drain("t6_drain", 0);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_block_loader.md
FIFO_BLOCK_LOADER -- requirements
Module: fifo_block_loader

Interface
REQ-001 Parameter BLK_BYTES, default 16, bytes per output block (AES-128 block).
REQ-002 Parameter DATA_W, default 8, FIFO read-data width in bits.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 fifo_empty  input  1  data FIFO has no entries.
REQ-006 fifo_r_data  input  DATA_W  FIFO head entry, valid whenever fifo_empty is low.
REQ-007 fifo_r_enable  output  1  pops the FIFO head at the next rising edge.
REQ-008 flush  input  1  single-cycle end-of-packet pulse from the USB receiver.
REQ-009 blk_ready  input  1  AES core accepts the presented block.
REQ-010 blk_valid  output  1  blk_data holds a complete block.
REQ-011 blk_data  output  BLK_BYTES*DATA_W  assembled block; first byte popped occupies the most-significant byte.
REQ-012 blk_last  output  1  the presented block is the final, padded block of a packet.

Function
REQ-013 States SHALL be FILL, PAD and HOLD; the byte counter cnt SHALL count from 0 to BLK_BYTES-1.
REQ-014 FILL: fifo_r_enable SHALL equal !fifo_empty, combinationally.
REQ-015 On each edge with fifo_r_enable high, the block SHALL shift left one byte, take fifo_r_data into the LSB, and increment cnt.
REQ-016 A pop when cnt = BLK_BYTES-1 SHALL clear cnt and move to HOLD; blk_valid SHALL be high on the next cycle, one cycle after the last pop.
REQ-017 HOLD: fifo_r_enable SHALL be 0; blk_data, blk_valid and blk_last SHALL stay stable until blk_ready is sampled high.
REQ-018 HOLD with blk_ready high SHALL move to FILL with blk_valid and blk_last low next cycle; no pop SHALL occur in that same cycle (one-cycle bubble).
REQ-019 blk_ready while not in HOLD SHALL be ignored.
REQ-020 A flush while in FILL with cnt > 0 SHALL set flush_pend; flush_pend plus fifo_empty in FILL SHALL move to PAD.
REQ-021 flush_pend SHALL defer PAD until the FIFO is empty; the FIFO SHALL drain first, including across intervening full blocks.
REQ-022 A flush with cnt = 0 and no bytes pending SHALL be ignored.
REQ-023 A flush arriving in HOLD or PAD SHALL set flush_pend for the following FILL.
REQ-024 PAD: the block SHALL shift in 0x00 bytes one per cycle until cnt wraps.
REQ-025 On the cnt wrap in PAD, the block SHALL enter HOLD with blk_last=1 and clear flush_pend.
REQ-026 PAD: fifo_r_enable SHALL be 0, even if the FIFO becomes non-empty.
REQ-027 fifo_r_enable SHALL never be high while fifo_empty is high.

Reset
REQ-028 While n_rst is low: state=FILL, cnt=0, flush_pend=0, blk_data=0, blk_valid=0, blk_last=0, fifo_r_enable=0.
REQ-029 Reset mid-block SHALL discard the partial block; no residual bytes SHALL appear after reset release.

Configuration
REQ-030 With the macro FIFO_LOADER_PAD_EN defined, flush and PAD SHALL behave per REQ-020 to REQ-026.
REQ-031 Without FIFO_LOADER_PAD_EN: the flush port SHALL remain present but be ignored, the PAD state SHALL not exist, blk_last SHALL be tied to 0, and partial blocks SHALL wait for more FIFO data.

Structure
REQ-032 Package aes_ctrl_pkg SHALL hold the state enum type, the BLK_BYTES default, and the block-width localparam.
REQ-033 The byte counter SHALL be an instance of the team's flex_counter with rollover value BLK_BYTES-1; there SHALL be no other sub-modules.

Verification
REQ-034 Push bytes 0x00..0x0F with blk_ready held 1 -> blk_valid one cycle after the 16th pop; blk_data=0x000102...0F; blk_last=0.
REQ-035 Push 40 bytes with blk_ready=0 -> exactly 16 pops, then fifo_r_enable=0 with blk_data stable; raise blk_ready -> bubble cycle, then pops resume.
REQ-036 (PAD_EN) Push 0xA1,0xA2,0xA3 then flush -> blk_data=0xA1A2A3 followed by 13 zero bytes; blk_last=1.
REQ-037 (PAD_EN) Push 20 bytes, flush while the FIFO is non-empty -> one full block with blk_last=0, then a padded block with 4 data bytes and blk_last=1.
REQ-038 Assert n_rst low after 7 pops, push 16 new bytes -> first block contains only the new bytes; all outputs are 0 during reset.
REQ-039 Keep fifo_empty toggling randomly with byte-accurate checking -> fifo_r_enable never high while fifo_empty is high; no byte lost or duplicated.
